// File: rtl/gray_to_bin_pipe.sv
// Two-stage Gray-to-binary decoder with valid/ready handshake.
// Also flags input steps that change more than one bit.
module gray_to_bin_pipe #(
  parameter int WIDTH      = 4,
  parameter int CHECK_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             step_err,
  output logic [7:0]       err_cnt,
  input  logic             err_clr
);

  logic             run;
  logic             s1_v;
  logic [WIDTH-1:0] s1_g;
  logic             s2_v;
  logic [WIDTH-1:0] s2_b;
  logic [WIDTH-1:0] dec;
  logic             s2_load;
  logic             s1_load;
  logic             in_fire;

  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = run && (!s1_v || s2_load);
  assign in_ready  = s1_load;
  assign in_fire   = in_valid && s1_load;
  assign out_valid = s2_v;
  assign bin_out   = s2_b;

  always_comb begin
    dec = '0;
    dec[WIDTH-1] = s1_g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ s1_g[i];
    end
  end

  // run holds in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_g <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) s1_g <= gray_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_b <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) s2_b <= dec;
    end
  end

  generate
    if (CHECK_STEP != 0) begin : g_chk
      logic             have_prev;
      logic [WIDTH-1:0] prev;
      logic [WIDTH-1:0] diff;
      logic [4:0]       pc;
      logic             viol;

      always_comb begin
        diff = gray_in ^ prev;
        pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
          pc = pc + {4'd0, diff[i]};
        end
        viol = in_fire && have_prev && (pc >= 5'd2);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          have_prev <= 1'b0;
          prev      <= '0;
        end else if (in_fire) begin
          have_prev <= 1'b1;
          prev      <= gray_in;
        end
      end

      // a clear coinciding with a violation leaves exactly that one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          step_err <= 1'b0;
          err_cnt  <= '0;
        end else if (err_clr) begin
          step_err <= viol;
          err_cnt  <= {7'd0, viol};
        end else if (viol) begin
          step_err <= 1'b1;
          if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
      end
    end else begin : g_nochk
      assign step_err = 1'b0;
      assign err_cnt  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Randomised and directed bench for gray_to_bin_pipe.
// Scoreboard queue plus an arithmetic step-error model.
module tb_gray_to_bin_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] bin_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         step_err;
  logic [7:0]   err_cnt;
  logic         err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  bit           have_prev;
  logic [W-1:0] prev;
  bit           m_err;
  int           m_cnt;
  bit           hold_chk;
  logic [W-1:0] hold_val;

  gray_to_bin_pipe #(.WIDTH(W), .CHECK_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .gray_in(gray_in), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .out_valid(out_valid), .out_ready(out_ready),
    .step_err(step_err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // binary value is the XOR of all right shifts of the Gray word
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input int i);
    logic [W-1:0] v;
    v = W'(i);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    q.delete();
    have_prev = 0;
    prev      = '0;
    m_err     = 0;
    m_cnt     = 0;
    hold_chk  = 0;
  endtask

  // one clock: called at a negedge with inputs already driven
  task automatic cycle();
    bit           fi, fo, viol;
    logic [W-1:0] exp;
    #1;
    fi = in_valid && in_ready;
    fo = out_valid && out_ready;
    if (hold_chk) begin
      n_checks++;
      if (out_valid !== 1'b1 || bin_out !== hold_val) begin
        n_fail++;
        $display("FAIL hold: got v=%b d=%h want v=1 d=%h",
                 out_valid, bin_out, hold_val);
      end
    end
    hold_chk = out_valid && !out_ready;
    hold_val = bin_out;
    if (fo) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL order: got %h want no word", bin_out);
      end else begin
        exp = q.pop_front();
        if (bin_out !== exp) begin
          n_fail++;
          $display("FAIL order: got %h want %h", bin_out, exp);
        end
      end
    end
    viol = fi && have_prev && ($countones(gray_in ^ prev) >= 2);
    if (err_clr) begin
      m_err = 0;
      m_cnt = 0;
    end
    if (viol) begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (fi) begin
      q.push_back(g2b(gray_in));
      prev      = gray_in;
      have_prev = 1;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (step_err !== m_err || err_cnt !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL err: got %b/%0d want %b/%0d",
               step_err, err_cnt, m_err, m_cnt);
    end
  endtask

  task automatic send(input logic [W-1:0] g);
    int guard;
    gray_in  = g;
    in_valid = 1'b1;
    guard = 0;
    #1;
    while (!in_ready && guard < 20) begin
      cycle();
      #1;
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send: in_ready stuck at %b want 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 20) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || bin_out !== '0 ||
        step_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_vals: got rdy=%b v=%b d=%h e=%b c=%0d want 0s",
               in_ready, out_valid, bin_out, step_err, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_early: got %b want 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after: got %b want 1", in_ready);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_all_codes();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      gray_in  = b2g(i);
      in_valid = 1'b1;
      cycle();
      if (i == 0) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL lat1: got v=%b want 0", out_valid);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || bin_out !== 4'd0) begin
          n_fail++;
          $display("FAIL lat2: got v=%b d=%h want v=1 d=0",
                   out_valid, bin_out);
        end
      end
    end
    in_valid = 1'b0;
    drain();
    n_checks++;
    if (step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL codes_err: got %b want 0", step_err);
    end
  endtask

  task automatic test_bad_step();
    send(4'b0000);
    send(4'b0011);
    drain();
    n_checks++;
    if (step_err !== 1'b1 || err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL bad_step: got %b/%0d want 1/1", step_err, err_cnt);
    end
  endtask

  task automatic test_wrap_repeat();
    logic [W-1:0] seq[7] = '{4'b0010, 4'b0110, 4'b0100, 4'b1100,
                             4'b1000, 4'b0000, 4'b0000};
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    foreach (seq[i]) send(seq[i]);
    drain();
    n_checks++;
    if (step_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap: got %b/%0d want 0/0", step_err, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray_in   = 4'b0001;
    cycle();
    gray_in   = 4'b0011;
    cycle();
    gray_in   = 4'b0010;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full: got in_ready=%b want 0", in_ready);
    end
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (q.size() != 2) begin
      n_fail++;
      $display("FAIL held: got %0d words want 2", q.size());
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      cycle();
    end
    n_checks++;
    if (err_cnt !== 8'd255 || step_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sat: got %b/%0d want 1/255", step_err, err_cnt);
    end
    gray_in = ~gray_in;
    err_clr = 1'b1;
    cycle();
    err_clr  = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (err_cnt !== 8'd1 || step_err !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_viol: got %b/%0d want 1/1", step_err, err_cnt);
    end
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray_in   = 4'b0101;
    cycle();
    gray_in   = 4'b1010;
    cycle();
    in_valid  = 1'b0;
    do_reset();
    out_ready = 1'b1;
    send(4'b1111);
    drain();
    n_checks++;
    if (step_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_rst: got %b/%0d want 0/0", step_err, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] g;
    g = prev;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 7) == 0) g = W'($urandom);
      else if ($urandom_range(0, 3) != 0) g = g ^ (W'(1) << $urandom_range(0, W - 1));
      gray_in = g;
      cycle();
    end
    err_clr = 1'b0;
    drain();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_codes();
    test_bad_step();
    test_wrap_repeat();
    test_backpressure();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
